// File: rtl/alu_sequencer_if.sv
// ALU operation encoding shared by the sequencer and its environment, plus the
// interface that bundles the request/response port and the ALU drive/return lines.
package alu_sequencer_pkg;
  typedef enum logic [2:0] {
    amp  = 3'd0,
    add  = 3'd1,
    sub  = 3'd2,
    lsc  = 3'd3,
    rsc  = 3'd4,
    band = 3'd5,
    bor  = 3'd6,
    bxor = 3'd7
  } math;
endpackage

interface alu_sequencer_if;
  import alu_sequencer_pkg::*;

  logic       req_valid;
  logic       req_ready;
  logic       req_cmd;
  math        req_op;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic       req_dst;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic [7:0] alu_x;
  logic [7:0] alu_y;
  math        alu_op;
  logic       alu_en;
  logic       alu_rs;
  logic [7:0] alu_r_in;
  logic [7:0] alu_s_in;

  // The sequencer side: takes commands and ALU results, drives ALU controls.
  modport slave (
    input  req_valid, req_cmd, req_op, req_a, req_b, req_dst, alu_r_in, alu_s_in,
    output req_ready, rsp_valid, rsp_data, alu_x, alu_y, alu_op, alu_en, alu_rs
  );

  // The environment side: the requester together with the ALU.
  modport master (
    output req_valid, req_cmd, req_op, req_a, req_b, req_dst, alu_r_in, alu_s_in,
    input  req_ready, rsp_valid, rsp_data, alu_x, alu_y, alu_op, alu_en, alu_rs
  );
endinterface

// File: rtl/alu_sequencer.sv
// Issue controller for the ALU: runs single pass-through ops or an 8x8 shift-add
// multiply made of ALU add/lsc steps, returning one 8-bit result per command.
module alu_sequencer
  import alu_sequencer_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  alu_sequencer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ISSUE, MADD, MSHF, DONE} state_t;

  state_t     state;
  state_t     next;

  logic [7:0] a_q;
  logic [7:0] b_q;
  math        op_q;
  logic       dst_q;
  logic [7:0] acc;
  logic [7:0] mcand;
  logic [7:0] mplier;
  logic [2:0] cnt;
  logic [7:0] rsp_data_q;

  logic       ready;
  logic       en;
  logic       rs;
  logic       rsp_valid;
  logic [7:0] x;
  logic [7:0] y;
  math        op;
  logic       last_shift;

  assign last_shift = (cnt == 3'd7);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q        <= 8'h00;
      b_q        <= 8'h00;
      op_q       <= amp;
      dst_q      <= 1'b0;
      acc        <= 8'h00;
      mcand      <= 8'h00;
      mplier     <= 8'h00;
      cnt        <= 3'd0;
      rsp_data_q <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            a_q   <= bus.req_a;
            b_q   <= bus.req_b;
            op_q  <= bus.req_op;
            dst_q <= bus.req_dst;
            if (bus.req_cmd) begin
              acc    <= 8'h00;
              mcand  <= bus.req_a;
              mplier <= bus.req_b;
              cnt    <= 3'd0;
            end
          end
        end
        ISSUE: rsp_data_q <= dst_q ? bus.alu_s_in : bus.alu_r_in;
        MADD:  acc <= bus.alu_r_in;
        MSHF: begin
          mcand  <= bus.alu_s_in;
          mplier <= mplier >> 1;
          cnt    <= cnt + 3'd1;
          if (last_shift) rsp_data_q <= acc;
        end
        default: ;
      endcase
    end
  end

  // ALU controls are decoded from state alone so idle/done cycles drive fixed values.
  always_comb begin
    next      = state;
    ready     = 1'b0;
    en        = 1'b0;
    x         = 8'h00;
    y         = 8'h00;
    op        = amp;
    rs        = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (bus.req_valid) begin
          if (!bus.req_cmd)      next = ISSUE;
          else if (bus.req_b[0]) next = MADD;
          else                   next = MSHF;
        end
      end
      ISSUE: begin
        en   = 1'b1;
        x    = a_q;
        y    = b_q;
        op   = op_q;
        rs   = dst_q;
        next = DONE;
      end
      MADD: begin
        en   = 1'b1;
        x    = acc;
        y    = mcand;
        op   = add;
        next = MSHF;
      end
      MSHF: begin
        en = 1'b1;
        x  = mcand;
        op = lsc;
        rs = 1'b1;
        // mplier[1] is the multiplier bit that becomes bit 0 after this shift.
        if (last_shift)     next = DONE;
        else if (mplier[1]) next = MADD;
        else                next = MSHF;
      end
      DONE: begin
        rsp_valid = 1'b1;
        next      = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  assign bus.req_ready = ready & ~rst;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.alu_x     = x;
  assign bus.alu_y     = y;
  assign bus.alu_op    = op;
  assign bus.alu_en    = en;
  assign bus.alu_rs    = rs;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU model plus a scoreboard of expected
// responses (data, ALU-active cycles, add count, s-destination count, latency).
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_sequencer_if bus();

  alu_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] alu_r;
  logic [7:0] alu_s;

  function automatic logic [7:0] alu_f(input math f, input logic [7:0] a, input logic [7:0] b);
    case (f)
      amp:     return a;
      add:     return a + b;
      sub:     return a - b;
      lsc:     return {a[6:0], b[0]};
      rsc:     return {b[0], a[7:1]};
      band:    return a & b;
      bor:     return a | b;
      default: return a ^ b;
    endcase
  endfunction

  // ALU: result is visible combinationally while enabled, latched at the edge.
  always_comb begin
    bus.alu_r_in = alu_r;
    bus.alu_s_in = alu_s;
    if (bus.alu_en) begin
      if (bus.alu_rs) bus.alu_s_in = alu_f(bus.alu_op, bus.alu_x, bus.alu_y);
      else            bus.alu_r_in = alu_f(bus.alu_op, bus.alu_x, bus.alu_y);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_r <= 8'h00;
      alu_s <= 8'h00;
    end else if (bus.alu_en) begin
      if (bus.alu_rs) alu_s <= alu_f(bus.alu_op, bus.alu_x, bus.alu_y);
      else            alu_r <= alu_f(bus.alu_op, bus.alu_x, bus.alu_y);
    end
  end

  typedef struct {
    logic [7:0] data;
    int         en;
    int         adds;
    int         rs1;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   acc_cyc  = 0;
  int   en_cnt   = 0;
  int   add_cnt  = 0;
  int   rs_cnt   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (rst) begin
      en_cnt  = 0;
      add_cnt = 0;
      rs_cnt  = 0;
    end else begin
      if (bus.alu_en) begin
        en_cnt++;
        if (bus.alu_op == add) add_cnt++;
        if (bus.alu_rs) rs_cnt++;
      end
      if (bus.rsp_valid) begin
        check_eq("rsp_expected", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check_eq("rsp_data", 32'(bus.rsp_data), 32'(e.data));
          check_eq("alu_cycles", en_cnt, e.en);
          check_eq("add_ops", add_cnt, e.adds);
          check_eq("rs_s_cycles", rs_cnt, e.rs1);
          check_eq("latency", cyc - acc_cyc, e.en + 1);
          check_eq("en_in_done", 32'(bus.alu_en), 32'd0);
        end
        en_cnt  = 0;
        add_cnt = 0;
        rs_cnt  = 0;
      end
    end
  endtask

  task automatic push_cmd(input logic cmd, input math f, input logic [7:0] a,
                          input logic [7:0] b, input logic dst);
    exp_t e;
    if (!cmd) begin
      e.data = alu_f(f, a, b);
      e.en   = 1;
      e.adds = (f == add) ? 1 : 0;
      e.rs1  = dst ? 1 : 0;
    end else begin
      e.data = 8'(a * b);
      e.en   = 8 + $countones(b);
      e.adds = $countones(b);
      e.rs1  = 8;
    end
    sb.push_back(e);
    bus.req_cmd   = cmd;
    bus.req_op    = f;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_dst   = dst;
    bus.req_valid = 1'b1;
  endtask

  task automatic wait_accept();
    for (int i = 0; i < 100; i++) begin
      if (bus.req_ready) begin
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        return;
      end
      tick();
    end
    check_eq("accept_timeout", 32'd0, 32'd1);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check_eq("drain", sb.size(), 0);
  endtask

  task automatic run(input logic cmd, input math f, input logic [7:0] a,
                     input logic [7:0] b, input logic dst);
    push_cmd(cmd, f, a, b, dst);
    wait_accept();
    wait_idle();
  endtask

  logic [7:0] ra;
  logic [7:0] rb;
  int         n;

  initial begin
    bus.req_valid = 1'b0;
    bus.req_cmd   = 1'b0;
    bus.req_op    = amp;
    bus.req_a     = 8'h00;
    bus.req_b     = 8'h00;
    bus.req_dst   = 1'b0;
    rst           = 1'b1;
    tick();
    tick();
    check_eq("rst_ready", 32'(bus.req_ready), 32'd0);
    check_eq("rst_en", 32'(bus.alu_en), 32'd0);
    check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    check_eq("rst_x", 32'(bus.alu_x), 32'd0);
    check_eq("rst_op", 32'(bus.alu_op), 32'(amp));
    rst = 1'b0;
    tick();
    check_eq("ready_after_rst", 32'(bus.req_ready), 32'd1);

    run(1'b0, add, 8'h35, 8'h1C, 1'b0);
    check_eq("single_add", 32'(bus.rsp_data), 32'h51);
    run(1'b0, sub, 8'h10, 8'h01, 1'b1);
    check_eq("single_sub", 32'(bus.rsp_data), 32'h0F);
    run(1'b1, amp, 8'h0D, 8'h0B, 1'b0);
    tick();
    check_eq("rsp_hold", 32'(bus.rsp_data), 32'h8F);
    run(1'b1, amp, 8'hFF, 8'hFF, 1'b0);
    check_eq("mul_ff", 32'(bus.rsp_data), 32'h01);
    run(1'b1, amp, 8'h10, 8'h10, 1'b0);
    run(1'b1, amp, 8'h37, 8'h00, 1'b0);
    run(1'b0, bxor, 8'hA5, 8'h3C, 1'b1);
    for (int i = 0; i < 4; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      run(1'b1, amp, ra, rb, 1'b0);
    end

    // Second command held valid during a multiply must wait for req_ready.
    push_cmd(1'b1, amp, 8'h03, 8'h05, 1'b0);
    wait_accept();
    push_cmd(1'b0, add, 8'h20, 8'h22, 1'b0);
    n = 0;
    while (!bus.req_ready && n < 100) begin
      tick();
      n++;
    end
    check_eq("busy_first_done", sb.size(), 1);
    check_eq("busy_wait", n, 12);
    wait_accept();
    wait_idle();
    check_eq("busy_second", 32'(bus.rsp_data), 32'h42);

    // Reset on the 5th ALU-active cycle of a multiply aborts it.
    push_cmd(1'b1, amp, 8'hFF, 8'hFF, 1'b0);
    wait_accept();
    n = 0;
    while (en_cnt < 5 && n < 50) begin
      tick();
      n++;
    end
    check_eq("abort_reach_5", en_cnt, 5);
    rst = 1'b1;
    void'(sb.pop_back());
    tick();
    check_eq("abort_en", 32'(bus.alu_en), 32'd0);
    check_eq("abort_x", 32'(bus.alu_x), 32'd0);
    check_eq("abort_y", 32'(bus.alu_y), 32'd0);
    check_eq("abort_op", 32'(bus.alu_op), 32'(amp));
    check_eq("abort_rs", 32'(bus.alu_rs), 32'd0);
    check_eq("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("abort_rsp_data", 32'(bus.rsp_data), 32'd0);
    check_eq("abort_ready", 32'(bus.req_ready), 32'd0);
    rst = 1'b0;
    tick();
    check_eq("abort_ready_after", 32'(bus.req_ready), 32'd1);
    for (int i = 0; i < 20; i++) tick();
    run(1'b1, amp, 8'h07, 8'h09, 1'b0);
    check_eq("post_abort_mul", 32'(bus.rsp_data), 32'h3F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Issue controller sitting on the driving side of the ALU operand/result interface. Accepts one command at a time over a valid/ready request port and drives the ALU's x, y, math_op, alu_en and alu_rs inputs cycle by cycle. It collects the ALU's r/s results and returns one 8-bit response per command. It supports single-op pass-through and an 8×8 shift-add multiply built only from ALU add and lsc operations.

## Interface
Parameters:
- none (8-bit datapath fixed by the ALU)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  command present
- req_ready  out  1  sequencer can accept; high only in IDLE
- req_cmd  in  1  0 = SINGLE, 1 = MUL
- req_op  in  math  ALU operation for SINGLE; ignored for MUL
- req_a  in  8  operand A (SINGLE x / MUL multiplicand)
- req_b  in  8  operand B (SINGLE y / MUL multiplier)
- req_dst  in  1  SINGLE result register: 0 = r, 1 = s
- rsp_valid  out  1  one-cycle pulse, result available
- rsp_data  out  8  result; held until next response
- alu_x, alu_y  out  8  ALU operands
- alu_op  out  math  ALU operation select
- alu_en  out  1  ALU enable; high only in issue states
- alu_rs  out  1  ALU destination: 0 = r, 1 = s
- alu_r_in, alu_s_in  in  8  ALU r_out / s_out, combinational in the cycle alu_en is high

## Operation
- Reset values: state IDLE, alu_en 0, alu_x 0, alu_y 0, alu_op amp, alu_rs 0, rsp_valid 0, rsp_data 0, internal acc/mcand/mplier/cnt 0. req_ready is 0 while rst is high and 1 in the first cycle after.
- States: IDLE, ISSUE, MADD, MSHF, DONE.
- IDLE: req_ready = 1. On an edge with req_valid & req_ready, latch cmd, op, a, b and dst.
  - SINGLE → ISSUE.
  - MUL → set acc = 0, mcand = a, mplier = b, cnt = 0. Go to MADD if b[0] else MSHF.
- ISSUE: drive alu_en = 1, x = a, y = b, op, rs = dst. At the edge, rsp_data ← (dst ? alu_s_in : alu_r_in). Go to DONE.
- MADD: drive alu_en = 1, x = acc, y = mcand, op = add, rs = 0. At the edge, acc ← alu_r_in. Go to MSHF.
- MSHF: drive alu_en = 1, x = mcand, y = 0x00, op = lsc, rs = 1 (zero-fill left shift). At the edge:
  - mcand ← alu_s_in; mplier ← mplier >> 1; cnt ← cnt + 1.
  - If cnt == 7: rsp_data ← acc, go to DONE.
  - Else go to MADD if mplier[1] else MSHF.
- DONE: rsp_valid = 1 for exactly this cycle, alu_en = 0, req_ready = 0. Go to IDLE.
- Arithmetic: MUL returns the low 8 bits of a×b (mod 256). No carry or overflow is reported.
- All ALU outputs other than alu_en are don't-care when alu_en = 0. They are still driven to defined values, never X.
- req_valid while not in IDLE is ignored. Requests are not queued, and the requester must hold fields until accepted.
- rst in any state aborts the command: no response is issued, and state and outputs return to reset values at that edge.

## Timing
- SINGLE: accept edge E0 → ISSUE cycle → DONE cycle (rsp_valid) → req_ready high in the following cycle. Response appears 2 cycles after acceptance; a new command can be accepted every 3 cycles.
- MUL: ALU-active cycles = 8 + popcount(b) (always 8 MSHF, one MADD per set multiplier bit). DONE follows immediately.
  - b = 0x00 gives 8 cycles; b = 0xFF gives 16 cycles.
- alu_en is never high in IDLE or DONE, so the ALU's latched r/s values are preserved between commands.
- rsp_data changes only at the edge entering DONE.

## Test plan
- SINGLE add, a = 0x35, b = 0x1C, dst = r → alu_en high exactly 1 cycle with alu_rs = 0; rsp_valid pulse, rsp_data = 0x51.
- SINGLE sub, a = 0x10, b = 0x01, dst = s → rsp_data = 0x0F; alu_rs = 1 during ISSUE.
- MUL a = 0x0D, b = 0x0B → exactly 11 alu_en cycles (3 add, 8 lsc); rsp_data = 0x8F.
- MUL wrap cases:
  - a = 0xFF, b = 0xFF → 16 alu_en cycles, rsp_data = 0x01.
  - a = 0x10, b = 0x10 → 9 cycles, rsp_data = 0x00.
  - b = 0x00 → 8 cycles, rsp_data = 0x00.
- Busy/reset:
  - Hold req_valid high with a second command during a MUL → second command is not accepted until req_ready returns.
  - Assert rst on the 5th MUL cycle → no rsp_valid; all outputs at reset values the next cycle; req_ready = 1 the cycle after rst deasserts.
